dispensador_vuelto: RTL and testbench
=====================================

# dispensador_vuelto

Change-dispensing controller, directly downstream of the coffee-machine controller. When the machine has served a drink and computed the change, it issues a one-cycle start with the change amount in units of 100 colones. This block then drives the coin-ejector outputs one coin at a time, using the largest coin first (500, then 100). It reports the remaining amount for the display path and signals completion.

## Interface
Parameters:
- PULSE_CYCLES, default 1: width of each coin-eject pulse in clk cycles; legal range ≥1.
- GAP_CYCLES, default 1: idle cycles after each pulse before the next coin; legal range ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request to dispense; sampled only in IDLE.
- monto  in  8  change amount in units of 100 colones, unsigned; captured on the accepted start.
- coin_500  out  1  eject one 500 coin while high; registered.
- coin_100  out  1  eject one 100 coin while high; registered.
- busy  out  1  high from the accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- restante  out  8  amount still to dispense, in units of 100; registered.

## Operation
- All outputs are registered. State and outputs update only on the rising edge of clk.
- States are IDLE, SEL, PULSE, GAP and DONE.
- IDLE
  - busy=0, done=0, coin_*=0.
  - If start=1: restante<=monto, state<=SEL.
  - start is ignored in every other state; there is no queueing.
- SEL (busy=1)
  - If restante≥5: coin_500<=1, restante<=restante−5, state<=PULSE.
  - Else if restante≥1: coin_100<=1, restante<=restante−1, state<=PULSE.
  - Else (restante=0): done<=1, state<=DONE.
- PULSE: the selected coin output stays high for exactly PULSE_CYCLES cycles, then coin_*<=0 and state<=GAP.
- GAP: all coin outputs are low for exactly GAP_CYCLES cycles, then state<=SEL.
- DONE: busy=1 and done=1 for one cycle, then done<=0, busy<=0, state<=IDLE.
- Coin count for amount m:
  - floor(m/5) pulses on coin_500, followed by (m mod 5) pulses on coin_100.
  - A coin_500 pulse never follows a coin_100 pulse within one transaction.
  - coin_500 and coin_100 are never high in the same cycle.
- Arithmetic:
  - restante is 8-bit unsigned and only ever decremented after a ≥5 or ≥1 check, so it never wraps.
  - The full 0..255 range of monto is legal.
- The internal cycle counter is wide enough for max(PULSE_CYCLES, GAP_CYCLES) and is cleared on every state entry.
- Reset behaviour:
  - rst=1 at any edge forces state=IDLE, coin_500=0, coin_100=0, busy=0, done=0, restante=0. rst has priority over start.
  - rst in the middle of a transaction abandons it: no further pulses and no done.

## Timing
- Let edge 0 be the edge on which start is accepted. SEL is active in the cycle after edge 0.
- Each coin takes 1+PULSE_CYCLES+GAP_CYCLES cycles (SEL + PULSE + GAP).
- With N = total coins:
  - done is high in the single cycle following edge N·(1+PULSE_CYCLES+GAP_CYCLES)+1.
  - busy falls one edge later.
- monto=0: done is high in the cycle after edge 1; no coin pulses.
- restante shows the post-decrement value starting in the same cycle the corresponding coin pulse rises.
- Back-to-back transactions: the earliest next accepted start is on the edge where the state is IDLE, i.e. the edge that ends the DONE cycle plus one.

## Test plan
- Reset: hold rst 2 cycles with start=1 and monto=9. Require all outputs 0 and no pulses for 10 cycles after rst falls, while start stays 0.
- monto=0, defaults:
  - Require done high in the cycle after edge 1.
  - Require no coin pulses, and busy high for exactly 2 cycles.
- monto=7, defaults:
  - Require coin_500 high during the cycle after edge 1, then coin_100 high during the cycles after edges 4 and 7.
  - Require done in the cycle after edge 10.
  - Require restante to read 2, 1, 0 in sequence.
- monto=13 with PULSE_CYCLES=3, GAP_CYCLES=2:
  - Require 2 coin_500 pulses then 3 coin_100 pulses, each exactly 3 cycles wide and separated by 3 low cycles.
  - Require done in the cycle after edge 31.
- start=1 with monto=4 asserted while busy during a monto=5 transaction: require it is ignored, giving exactly 1 coin_500 pulse, 0 coin_100 pulses and restante=0 at done.
- rst asserted during the second coin_100 pulse of monto=3:
  - Require coin_100 low, busy=0 and restante=0 from the next edge.
  - Require no done.
  - Require that a new start with monto=1 then yields exactly one coin_100 pulse.

Source files
------------

// File: rtl/dispensador_vuelto.sv
// rtl/dispensador_vuelto.sv - change dispenser: ejects 500 then 100 coins for a given amount
module dispensador_vuelto #(
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] monto,
  output logic       coin_500,
  output logic       coin_100,
  output logic       busy,
  output logic       done,
  output logic [7:0] restante
);

  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    restante_q, restante_d;
  logic          coin_500_q, coin_500_d;
  logic          coin_100_q, coin_100_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      restante_q <= 8'd0;
      coin_500_q <= 1'b0;
      coin_100_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      restante_q <= restante_d;
      coin_500_q <= coin_500_d;
      coin_100_q <= coin_100_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  // Counter restarts at zero whenever a state is left; it only advances while dwelling
  always_comb begin
    state_d    = state_q;
    restante_d = restante_q;
    coin_500_d = coin_500_q;
    coin_100_d = coin_100_q;
    busy_d     = busy_q;
    done_d     = done_q;
    cnt_d      = '0;
    case (state_q)
      S_IDLE: begin
        coin_500_d = 1'b0;
        coin_100_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        if (start) begin
          restante_d = monto;
          busy_d     = 1'b1;
          state_d    = S_SEL;
        end
      end
      S_SEL: begin
        if (restante_q >= 8'd5) begin
          coin_500_d = 1'b1;
          restante_d = restante_q - 8'd5;
          state_d    = S_PULSE;
        end else if (restante_q != 8'd0) begin
          coin_100_d = 1'b1;
          restante_d = restante_q - 8'd1;
          state_d    = S_PULSE;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          coin_500_d = 1'b0;
          coin_100_d = 1'b0;
          state_d    = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SEL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign coin_500 = coin_500_q;
  assign coin_100 = coin_100_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign restante = restante_q;

endmodule

// File: tb/tb_dispensador_vuelto.sv
// tb/tb_dispensador_vuelto.sv - bench for dispensador_vuelto, default and 3/2 pulse/gap instances
module tb_dispensador_vuelto;

  typedef struct {
    int monto;
    int n5;
    int n1;
    int lat;
    int pw;
    int gw;
  } exp_t;

  typedef struct {
    int inst;
    int monto;
    int n5;
    int n1;
    int lat;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start_s  [2];
  logic [7:0] monto_s  [2];
  logic       c5_s     [2];
  logic       c1_s     [2];
  logic       bz_s     [2];
  logic       dn_s     [2];
  logic [7:0] rs_s     [2];

  int   sel;
  logic m_c5, m_c1, m_bz, m_dn;
  logic [7:0] m_rs;

  int   n_cmp;
  int   n_fail;
  exp_t sb_q[$];
  vec_t vecs[10];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dispensador_vuelto #(
      .PULSE_CYCLES((g == 0) ? 1 : 3),
      .GAP_CYCLES  ((g == 0) ? 1 : 2)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_s[g]),
      .monto   (monto_s[g]),
      .coin_500(c5_s[g]),
      .coin_100(c1_s[g]),
      .busy    (bz_s[g]),
      .done    (dn_s[g]),
      .restante(rs_s[g])
    );
  end

  assign m_c5 = (sel == 1) ? c5_s[1] : c5_s[0];
  assign m_c1 = (sel == 1) ? c1_s[1] : c1_s[0];
  assign m_bz = (sel == 1) ? bz_s[1] : bz_s[0];
  assign m_dn = (sel == 1) ? dn_s[1] : dn_s[0];
  assign m_rs = (sel == 1) ? rs_s[1] : rs_s[0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: accumulates pulse statistics per transaction, pops on done
  initial begin
    int   n5, n1, bcnt, first_rs, exp_rem, order_bad, both, run, npulse;
    int   wmin, wmax, gmin, gmax;
    logic cur, cur_prev, bz_prev;
    exp_t e;
    n5 = 0; n1 = 0; bcnt = 0; first_rs = 0; exp_rem = 0; order_bad = 0; both = 0;
    run = 0; npulse = 0; wmin = 0; wmax = 0; gmin = 0; gmax = 0;
    cur_prev = 1'b0;
    bz_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (m_bz === 1'b1 && bz_prev !== 1'b1) begin
        n5 = 0; n1 = 0; bcnt = 0; first_rs = int'(m_rs); exp_rem = int'(m_rs);
        order_bad = 0; both = 0; run = 0; npulse = 0;
        wmin = 1000; wmax = 0; gmin = 1000; gmax = 0;
      end
      if (m_bz === 1'b1) bcnt++;
      if (m_c5 === 1'b1 && m_c1 === 1'b1) both++;
      cur = (m_c5 === 1'b1) || (m_c1 === 1'b1);
      if (cur && !cur_prev) begin
        if (m_c5 === 1'b1) begin
          n5++;
          if (n1 > 0) order_bad++;
          exp_rem = exp_rem - 5;
        end else begin
          n1++;
          exp_rem = exp_rem - 1;
        end
        chk("restante_step", int'(m_rs), exp_rem);
        if (npulse > 0) begin
          if (run < gmin) gmin = run;
          if (run > gmax) gmax = run;
        end
        npulse++;
        run = 1;
      end else if (cur == cur_prev) begin
        run++;
      end else begin
        if (run < wmin) wmin = run;
        if (run > wmax) wmax = run;
        run = 1;
      end
      if (m_dn === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("n_coin500", n5, e.n5);
          chk("n_coin100", n1, e.n1);
          chk("done_latency", bcnt - 1, e.lat);
          chk("captured_monto", first_rs, e.monto);
          chk("restante_at_done", int'(m_rs), 0);
          chk("order_500_after_100", order_bad, 0);
          chk("both_coins_high", both, 0);
          if (npulse > 0) begin
            chk("pulse_width_min", wmin, e.pw);
            chk("pulse_width_max", wmax, e.pw);
          end
          if (npulse > 1) begin
            chk("gap_min", gmin, e.gw);
            chk("gap_max", gmax, e.gw);
          end
        end
      end
      bz_prev  = m_bz;
      cur_prev = cur;
    end
  end

  task automatic run_txn(input int inst, input int m, input int n5, input int n1, input int lat);
    int got;
    sel = inst;
    sb_q.push_back('{m, n5, n1, lat, (inst == 0) ? 1 : 3, (inst == 0) ? 2 : 3});
    start_s[inst] = 1'b1;
    monto_s[inst] = 8'(m);
    @(negedge clk);
    start_s[inst] = 1'b0;
    monto_s[inst] = 8'($urandom_range(0, 255));
    got = 0;
    for (int k = 0; k < 2000; k++) begin
      if (m_dn === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("busy_fall", int'(m_bz), 0);
  endtask

  initial begin
    int quiet, got;
    int t_c5[12];
    int t_c1[12];
    int t_rs[12];
    int t_bz[12];
    int t_dn[12];
    n_cmp  = 0;
    n_fail = 0;
    sel    = 0;
    vecs[0] = '{0, 0,   0,  0, 1};
    vecs[1] = '{0, 5,   1,  0, 4};
    vecs[2] = '{0, 4,   0,  4, 13};
    vecs[3] = '{0, 9,   1,  4, 16};
    vecs[4] = '{0, 10,  2,  0, 7};
    vecs[5] = '{0, 255, 51, 0, 154};
    vecs[6] = '{0, 254, 50, 4, 163};
    vecs[7] = '{1, 13,  2,  3, 31};
    vecs[8] = '{1, 0,   0,  0, 1};
    vecs[9] = '{1, 6,   1,  1, 13};
    t_c5 = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    t_c1 = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    t_rs = '{7, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0, 0};
    t_bz = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    t_dn = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b1;
      monto_s[i] = 8'd9;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_coin500", int'(c5_s[i]), 0);
      chk("reset_coin100", int'(c1_s[i]), 0);
      chk("reset_busy", int'(bz_s[i]), 0);
      chk("reset_done", int'(dn_s[i]), 0);
      chk("reset_restante", int'(rs_s[i]), 0);
    end
    rst = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (c5_s[i] !== 1'b0 || c1_s[i] !== 1'b0 || bz_s[i] !== 1'b0 ||
            dn_s[i] !== 1'b0 || rs_s[i] !== 8'd0) quiet++;
    end
    chk("reset_quiet", quiet, 0);

    for (int v = 0; v < 10; v++)
      run_txn(vecs[v].inst, vecs[v].monto, vecs[v].n5, vecs[v].n1, vecs[v].lat);

    // monto=7 cycle-by-cycle trace on the default instance
    sel = 0;
    sb_q.push_back('{7, 1, 2, 10, 1, 2});
    start_s[0] = 1'b1;
    monto_s[0] = 8'd7;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("m7_coin500_e%0d", i), int'(c5_s[0]), t_c5[i]);
      chk($sformatf("m7_coin100_e%0d", i), int'(c1_s[0]), t_c1[i]);
      chk($sformatf("m7_restante_e%0d", i), int'(rs_s[0]), t_rs[i]);
      chk($sformatf("m7_busy_e%0d", i), int'(bz_s[0]), t_bz[i]);
      chk($sformatf("m7_done_e%0d", i), int'(dn_s[0]), t_dn[i]);
      if (i < 11) @(negedge clk);
    end

    // start while busy must be ignored
    sb_q.push_back('{5, 1, 0, 4, 1, 2});
    start_s[0] = 1'b1;
    monto_s[0] = 8'd5;
    @(negedge clk);
    monto_s[0] = 8'd4;
    repeat (3) @(negedge clk);
    start_s[0] = 1'b0;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      if (dn_s[0] === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("ignore_done_seen", got, 1);
    @(negedge clk);
    chk("ignore_busy_fall", int'(bz_s[0]), 0);
    repeat (4) @(negedge clk);
    chk("ignore_no_restart", int'(bz_s[0]), 0);

    // reset during the second coin_100 pulse of monto=3
    start_s[0] = 1'b1;
    monto_s[0] = 8'd3;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_second_pulse_high", int'(c1_s[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_coin100", int'(c1_s[0]), 0);
    chk("abort_busy", int'(bz_s[0]), 0);
    chk("abort_restante", int'(rs_s[0]), 0);
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dn_s[0] !== 1'b0 || c1_s[0] !== 1'b0 || c5_s[0] !== 1'b0 || bz_s[0] !== 1'b0) quiet++;
    end
    chk("abort_no_activity", quiet, 0);
    run_txn(0, 1, 0, 1, 4);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
